dlx_hazard_ctrl: RTL and testbench

DLX_HAZARD_CTRL -- requirements
Module: dlx_hazard_ctrl

---
 rtl/dlx_hazard_ctrl.sv | 76 +++++++
 tb/tb_dlx_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dlx_hazard_ctrl.sv
// dlx_hazard_ctrl: DLX pipeline stall/flush controller (RAW detection against EX and MEM, branch flush, counters)
//   in : clk, reset (async, active-high), id_rs/id_rt + id_uses_rs/id_uses_rt (ID sources),
//        ex_rd/ex_reg_write, mem_rd/mem_reg_write (pending writers), mem_pcsrc (taken branch in MEM)
//   out: pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush (zero-latency controls),
//        state (RUN=00 STALL=01 FLUSH=10), stall_cycles, flush_events (saturating), hazard_err (sticky overrun)
module dlx_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_pcsrc,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
  output logic        hazard_err
);
  localparam logic [1:0] RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10;
  logic [1:0]  state_q, state_d, stall_run_q, stall_run_d;
  logic [15:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  logic        hazard_err_q, hazard_err_d;
  logic        raw_ex, raw_mem, hazard, stall;
  assign raw_ex  = ex_reg_write && ex_rd != 5'd0 &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  assign raw_mem = mem_reg_write && mem_rd != 5'd0 &&
                   ((id_uses_rs && id_rs == mem_rd) || (id_uses_rt && id_rt == mem_rd));
  // the cycle after a flush, ID holds a bubble, so its source fields are meaningless
  assign hazard  = (raw_ex || raw_mem) && state_q != FLUSH;
  assign stall   = hazard && !mem_pcsrc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      stall_run_q    <= 2'd0;
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
      hazard_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_run_q    <= stall_run_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      hazard_err_q   <= hazard_err_d;
    end
  end
  always_comb begin
    state_d        = mem_pcsrc ? FLUSH : stall ? STALL : RUN;
    stall_run_d    = !stall ? 2'd0 : stall_run_q == 2'd3 ? 2'd3 : stall_run_q + 2'd1;
    stall_cycles_d = (stall && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
    flush_events_d = (mem_pcsrc && flush_events_q != 16'hFFFF) ? flush_events_q + 16'd1 : flush_events_q;
    hazard_err_d   = hazard_err_q || (stall && stall_run_q == 2'd2);
  end
  // reset gates the controls directly so they drop before any clock edge
  always_comb begin
    pc_write     = !reset && !stall;
    if_id_write  = !reset && !stall;
    id_ex_bubble = !reset && stall;
    if_id_flush  = !reset && mem_pcsrc;
    id_ex_flush  = !reset && mem_pcsrc;
    ex_mem_flush = !reset && mem_pcsrc;
  end
  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign hazard_err   = hazard_err_q;
endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// tb_dlx_hazard_ctrl: table vectors, directed corner sequences and a randomized run against a reference model
module tb_dlx_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, ex_reg_write, mem_reg_write, mem_pcsrc;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, hazard_err;
  logic [1:0] state;
  logic [15:0] stall_cycles, flush_events;
  int checks = 0, errors = 0;
  int m_state, m_stall, m_flush, m_run;
  bit m_err;

  dlx_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_pcsrc(mem_pcsrc), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic urs, urt;
    logic [4:0] exrd;
    logic exw;
    logic [4:0] memrd;
    logic memw, br;
    logic pc, ifid, bub, fl;
    logic [1:0] nst;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, rt, input logic urs, urt, input logic [4:0] exrd,
                        input logic exw, input logic [4:0] memrd, input logic memw, br);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; ex_rd = exrd;
    ex_reg_write = exw; mem_rd = memrd; mem_reg_write = memw; mem_pcsrc = br;
  endtask

  function automatic bit reads(input logic [4:0] rd, input logic w);
    return w && rd != 0 && ((id_uses_rs && id_rs == rd) || (id_uses_rt && id_rt == rd));
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // called at posedge+1 with inputs applied; checks controls mid-cycle, registers after the edge
  task automatic step();
    bit st;
    #3;
    st = (reads(ex_rd, ex_reg_write) || reads(mem_rd, mem_reg_write)) && m_state != 2 && !mem_pcsrc;
    chk("pc_write", pc_write, !st);
    chk("if_id_write", if_id_write, !st);
    chk("id_ex_bubble", id_ex_bubble, st);
    chk("flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, mem_pcsrc ? 7 : 0);
    @(posedge clk);
    if (mem_pcsrc) begin
      m_state = 2; m_run = 0; m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
    end else if (st) begin
      if (m_run >= 2) m_err = 1;
      m_run++; m_state = 1; m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
    end else begin
      m_state = 0; m_run = 0;
    end
    #1;
    chk("state", state, m_state);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_events", flush_events, m_flush);
    chk("hazard_err", hazard_err, m_err);
  endtask

  initial begin
    tbl[0] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 5'd0, 0, 0, 0, 0, 1, 0, 2'b01};
    tbl[1] = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 5'd0, 0, 0, 1, 1, 0, 0, 2'b00};
    tbl[2] = '{5'd0, 5'd5, 0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 1, 0, 2'b01};
    tbl[3] = '{5'd0, 5'd5, 0, 0, 5'd0, 0, 5'd5, 1, 0, 1, 1, 0, 0, 2'b00};
    tbl[4] = '{5'd7, 5'd0, 1, 0, 5'd7, 0, 5'd0, 0, 0, 1, 1, 0, 0, 2'b00};
    tbl[5] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 5'd0, 0, 1, 1, 1, 0, 1, 2'b10};
    tbl[6] = '{5'd1, 5'd2, 1, 1, 5'd4, 1, 5'd6, 1, 1, 1, 1, 0, 1, 2'b10};
    tbl[7] = '{5'd9, 5'd10, 1, 1, 5'd10, 1, 5'd0, 0, 0, 0, 0, 1, 0, 2'b01};
    tbl[8] = '{5'd4, 5'd0, 1, 0, 5'd5, 1, 5'd6, 1, 0, 1, 1, 0, 0, 2'b00};
    tbl[9] = '{5'd0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 1, 0, 1, 1, 0, 0, 2'b00};

    // reset holds every control low even with a branch request present
    set_in(5'd3, 0, 1, 0, 5'd3, 1, 0, 0, 1);
    #2;
    chk("rst pc_write", pc_write, 0);
    chk("rst if_id_write", if_id_write, 0);
    chk("rst flushes", {if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble}, 0);
    chk("rst state", state, 0);
    do_reset();
    #1;
    chk("post-rst pc_write", pc_write, 1);
    chk("post-rst counters", {stall_cycles, flush_events}, 0);
    chk("post-rst hazard_err", hazard_err, 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].exrd, tbl[i].exw,
             tbl[i].memrd, tbl[i].memw, tbl[i].br);
      #3;
      chk($sformatf("vec%0d ctl", i), {pc_write, if_id_write, id_ex_bubble}, {tbl[i].pc, tbl[i].ifid, tbl[i].bub});
      chk($sformatf("vec%0d flush", i), {if_id_flush, id_ex_flush, ex_mem_flush}, {3{tbl[i].fl}});
      @(posedge clk); #1;
      chk($sformatf("vec%0d next", i), state, tbl[i].nst);
    end

    // EX match, then MEM match, then a third stall cycle trips the overrun flag
    do_reset();
    set_in(5'd3, 0, 1, 0, 5'd3, 1, 0, 0, 0); step();
    set_in(5'd3, 0, 1, 0, 5'd0, 0, 5'd3, 1, 0); step();
    chk("two stalls err", hazard_err, 0);
    chk("two stalls count", stall_cycles, 2);
    step();
    chk("third stall err", hazard_err, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    chk("err sticky", hazard_err, 1);

    // branch coincident with a hazard, then hazard inputs held through the FLUSH cycle
    do_reset();
    set_in(5'd3, 0, 1, 0, 5'd3, 1, 0, 0, 1); step();
    chk("br+hz state", state, 2);
    set_in(5'd3, 0, 1, 0, 5'd3, 1, 0, 0, 0); step();
    chk("flush->run", state, 0);
    chk("flush count", flush_events, 1);
    chk("no stall in flush", stall_cycles, 0);

    // branch aborting a stall
    do_reset();
    set_in(5'd2, 0, 1, 0, 5'd2, 1, 0, 0, 0); step(); step();
    set_in(5'd2, 0, 1, 0, 5'd2, 1, 0, 0, 1); step();
    set_in(5'd2, 0, 1, 0, 5'd2, 1, 0, 0, 0); step(); step();
    chk("abort stall err", hazard_err, 0);

    // asynchronous reset in the middle of a STALL cycle
    do_reset();
    set_in(5'd3, 0, 1, 0, 5'd3, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("pre-async state", state, 1);
    reset = 1'b1; #1;
    chk("async pc_write", pc_write, 0);
    chk("async bubble", id_ex_bubble, 0);
    chk("async state", state, 0);
    chk("async stall_cycles", stall_cycles, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("release pc_write", pc_write, 1);
    chk("release state", state, 0);
    #2; @(posedge clk); #1;

    // randomized run; small register numbers make matches frequent
    for (int n = 0; n < 3000; n++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             $urandom_range(0, 9) == 0);
      step();
    end

    // stall counter saturation
    do_reset();
    set_in(5'd3, 0, 1, 0, 5'd3, 1, 0, 0, 0);
    repeat (65534) @(posedge clk);
    #1;
    chk("stall 0xFFFE", stall_cycles, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("stall saturate", stall_cycles, 16'hFFFF);
    chk("sat err", hazard_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
